logic_gate_explorer: RTL and testbench
======================================

LOGIC_GATE_EXPLORER -- requirements
Module: logic_gate_explorer

Interface
REQ-001 Parameter W, default 4, operand width in bits; legal range 1..6.
REQ-002 Parameter STEP_DIV, default 8, clock cycles per sweep step; legal range 1..65535.
REQ-003 Port clock  in  1  single clock; all state updates on rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port a_in  in  W  manual operand A.
REQ-006 Port b_in  in  W  manual operand B.
REQ-007 Port op_sel  in  3  operation: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A, 7 NOT B.
REQ-008 Port mode_sweep  in  1  0 = manual, 1 = truth-table sweep.
REQ-009 Port start  in  1  one-cycle pulse; starts a sweep.
REQ-010 Port fault_inj  in  1  inverts bit 0 of both second-form De Morgan expressions, for checker self-test.
REQ-011 Port a_cur  out  W  operand A currently applied.
REQ-012 Port b_cur  out  W  operand B currently applied.
REQ-013 Port result  out  W  registered op_sel result of a_cur, b_cur.
REQ-014 Port demorgan_ok  out  1  1 when both De Morgan identities hold bitwise for a_cur, b_cur.
REQ-015 Port busy  out  1  high while a sweep runs.
REQ-016 Port done  out  1  one-cycle pulse at sweep completion.
REQ-017 Port vector_cnt  out  2W+1  number of vectors checked in the current or last sweep.
REQ-018 Port mismatch_cnt  out  8  vectors failing either identity, saturating at 255.

Function
REQ-019 The block SHALL implement FSM states IDLE, RUN, DONE.
REQ-020 In IDLE, a_cur/b_cur SHALL register a_in/b_in each cycle: 1-cycle latency to a_cur, 2 cycles to result/demorgan_ok.
REQ-021 In IDLE with start=1 and mode_sweep=1, the FSM SHALL enter RUN next cycle: {a_cur,b_cur}=0, prescaler=0, vector_cnt=0, mismatch_cnt=0.
REQ-022 In IDLE, start with mode_sweep=0 SHALL be ignored.
REQ-023 In RUN, the prescaler SHALL count 0..STEP_DIV-1; at terminal count the current vector SHALL be checked, vector_cnt incremented, and {a_cur,b_cur} (A is the high half) incremented by 1.
REQ-024 Check: form1 = ~(A&B) vs ~A|~B, form2 = ~(A|B) vs ~A&~B, all W bits; any bit difference SHALL increment mismatch_cnt by 1 (saturate at 255).
REQ-025 With fault_inj=1, bit 0 of ~A|~B and of ~A&~B SHALL be inverted before comparison; with fault_inj=0 mismatch_cnt SHALL remain 0.
REQ-026 When the vector checked is {a_cur,b_cur} all ones, the FSM SHALL enter DONE instead of wrapping; vector_cnt SHALL then equal 2^(2W).
REQ-027 DONE SHALL last exactly one cycle with done=1, then return to IDLE; a_cur/b_cur resume tracking a_in/b_in from IDLE.
REQ-028 busy SHALL be 1 in RUN only.
REQ-029 start asserted during RUN or DONE SHALL be ignored.
REQ-030 mode_sweep deasserted during RUN SHALL abort to IDLE next cycle without done; vector_cnt and mismatch_cnt hold their values.
REQ-031 vector_cnt and mismatch_cnt SHALL hold after DONE until the next sweep start or reset.
REQ-032 result and demorgan_ok SHALL be registered from a_cur, b_cur, op_sel in all states (1-cycle latency); demorgan_ok SHALL include fault_inj effect.
REQ-033 op_sel changes SHALL be reflected on result one cycle later in any state, without disturbing the sweep.

Reset
REQ-034 reset=1 at any clock edge, including mid-RUN, SHALL force: state IDLE, a_cur=0, b_cur=0, result=0, demorgan_ok=0, busy=0, done=0, vector_cnt=0, mismatch_cnt=0, prescaler=0.
REQ-035 The first a_in/b_in capture SHALL occur on the first edge with reset=0.

Verification
REQ-036 Manual: W=4, op_sel=0, a_in=4'hC, b_in=4'hA -> a_cur=C after 1 cycle, result=4'h8 and demorgan_ok=1 after 2 cycles; op_sel=2 -> result=4'h6 one cycle later.
REQ-037 Full sweep: W=2, STEP_DIV=1, fault_inj=0, start -> busy for 16 cycles, done pulse once, vector_cnt=16, mismatch_cnt=0.
REQ-038 Fault sweep: W=2, STEP_DIV=3, fault_inj=1 -> sweep lasts 48 RUN cycles, vector_cnt=16, mismatch_cnt=16, demorgan_ok=0 throughout.
REQ-039 Abort: W=3, STEP_DIV=2, drop mode_sweep after 10 RUN cycles -> IDLE next cycle, done=0, vector_cnt=5 held.
REQ-040 Reset mid-run: assert reset during RUN -> all outputs 0 next cycle; start during RUN ignored (vector_cnt continues monotonically).
REQ-041 Saturation: W=5, STEP_DIV=1, fault_inj=1 -> vector_cnt=1024, mismatch_cnt=255 at done.

Source files
------------

// File: rtl/logic_gate_explorer.sv
// logic_gate_explorer: registered bitwise gate unit with a De Morgan
// self-checking truth-table sweep engine.
module logic_gate_explorer #(
  parameter int W        = 4,
  parameter int STEP_DIV = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
  input  logic [2:0]     op_sel,
  input  logic           mode_sweep,
  input  logic           start,
  input  logic           fault_inj,
  output logic [W-1:0]   a_cur,
  output logic [W-1:0]   b_cur,
  output logic [W-1:0]   result,
  output logic           demorgan_ok,
  output logic           busy,
  output logic           done,
  output logic [2*W:0]   vector_cnt,
  output logic [7:0]     mismatch_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [15:0] PRE_TC = 16'(STEP_DIV - 1);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_result;
  logic           r_dm_ok;
  logic [15:0]    r_pre;
  logic [2*W:0]   r_vcnt;
  logic [7:0]     r_mcnt;

  logic [W-1:0]   w_flip;
  logic [W-1:0]   w_nand;
  logic [W-1:0]   w_or_n;
  logic [W-1:0]   w_nor;
  logic [W-1:0]   w_and_n;
  logic           w_dm_ok;
  logic [W-1:0]   w_op_res;
  logic           w_tc;
  logic           w_last;
  logic           w_go;
  logic [2*W-1:0] w_ab_inc;
  logic           w_busy;
  logic           w_done;

  // fault injection flips only bit 0 of the second forms
  assign w_flip   = W'(fault_inj);
  assign w_nand   = ~(r_a & r_b);
  assign w_or_n   = (~r_a | ~r_b) ^ w_flip;
  assign w_nor    = ~(r_a | r_b);
  assign w_and_n  = (~r_a & ~r_b) ^ w_flip;
  assign w_dm_ok  = (w_nand == w_or_n) &&
                    (w_nor == w_and_n);

  assign w_tc     = (r_pre == PRE_TC);
  assign w_last   = &{r_a, r_b};
  assign w_go     = start && mode_sweep;
  assign w_ab_inc = {r_a, r_b} + (2*W)'(1);

  // selected gate function of the applied operands
  always_comb begin
    w_op_res = '0;
    unique case (op_sel)
      3'd0:    w_op_res = r_a & r_b;
      3'd1:    w_op_res = r_a | r_b;
      3'd2:    w_op_res = r_a ^ r_b;
      3'd3:    w_op_res = ~(r_a & r_b);
      3'd4:    w_op_res = ~(r_a | r_b);
      3'd5:    w_op_res = ~(r_a ^ r_b);
      3'd6:    w_op_res = ~r_a;
      3'd7:    w_op_res = ~r_b;
      default: w_op_res = '0;
    endcase
  end

  // sweep state register
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // next-state and status outputs; abort wins over completion
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_go) w_state_nxt = RUN;
      end
      RUN: begin
        w_busy = 1'b1;
        if (!mode_sweep)
          w_state_nxt = IDLE;
        else if (w_tc && w_last)
          w_state_nxt = DONE;
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // operand, prescaler, counters and registered result/check
  always_ff @(posedge clock) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_dm_ok  <= 1'b0;
      r_pre    <= '0;
      r_vcnt   <= '0;
      r_mcnt   <= '0;
    end else begin
      r_result <= w_op_res;
      r_dm_ok  <= w_dm_ok;
      unique case (r_state)
        IDLE: begin
          if (w_go) begin
            r_a    <= '0;
            r_b    <= '0;
            r_pre  <= '0;
            r_vcnt <= '0;
            r_mcnt <= '0;
          end else begin
            r_a <= a_in;
            r_b <= b_in;
          end
        end
        RUN: begin
          if (mode_sweep) begin
            if (w_tc) begin
              r_pre  <= '0;
              r_vcnt <= r_vcnt + (2*W+1)'(1);
              if (!w_dm_ok && r_mcnt != 8'hFF)
                r_mcnt <= r_mcnt + 8'd1;
              if (!w_last)
                {r_a, r_b} <= w_ab_inc;
            end else begin
              r_pre <= r_pre + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign a_cur        = r_a;
  assign b_cur        = r_b;
  assign result       = r_result;
  assign demorgan_ok  = r_dm_ok;
  assign busy         = w_busy;
  assign done         = w_done;
  assign vector_cnt   = r_vcnt;
  assign mismatch_cnt = r_mcnt;

endmodule

// File: tb/tb_logic_gate_explorer.sv
// tb_logic_gate_explorer: five parameterisations of logic_gate_explorer
// driven by directed and random steps against a behavioural model.
module tb_logic_gate_explorer;

  function automatic int wof(int k);
    case (k)
      0:       return 4;
      1:       return 2;
      2:       return 2;
      3:       return 3;
      default: return 5;
    endcase
  endfunction

  function automatic int sdof(int k);
    case (k)
      0:       return 8;
      1:       return 1;
      2:       return 3;
      3:       return 2;
      default: return 1;
    endcase
  endfunction

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] a_in = '0;
  logic [5:0] b_in = '0;
  logic [2:0] op_sel = '0;
  logic       fault_inj = 1'b0;
  logic [4:0] start = '0;
  logic [4:0] mode = '0;

  logic [5:0]  ac_v [5];
  logic [5:0]  bc_v [5];
  logic [5:0]  res_v [5];
  logic [10:0] vc_v [5];
  logic [7:0]  mc_v [5];
  logic        dm_v [5];
  logic        bz_v [5];
  logic        dn_v [5];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  for (genvar k = 0; k < 5; k++) begin : g
    localparam int WK = wof(k);
    localparam int SK = sdof(k);
    logic [WK-1:0] ac, bc, res;
    logic [2*WK:0] vc;
    logic [7:0]    mc;
    logic          dm, bz, dn;
    logic_gate_explorer #(.W(WK), .STEP_DIV(SK)) u_dut (
      .clock        (clock),
      .reset        (reset),
      .a_in         (a_in[WK-1:0]),
      .b_in         (b_in[WK-1:0]),
      .op_sel       (op_sel),
      .mode_sweep   (mode[k]),
      .start        (start[k]),
      .fault_inj    (fault_inj),
      .a_cur        (ac),
      .b_cur        (bc),
      .result       (res),
      .demorgan_ok  (dm),
      .busy         (bz),
      .done         (dn),
      .vector_cnt   (vc),
      .mismatch_cnt (mc)
    );
    assign ac_v[k]  = 6'(ac);
    assign bc_v[k]  = 6'(bc);
    assign res_v[k] = 6'(res);
    assign vc_v[k]  = 11'(vc);
    assign mc_v[k]  = mc;
    assign dm_v[k]  = dm;
    assign bz_v[k]  = bz;
    assign dn_v[k]  = dn;
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [5:0] ref_op(logic [5:0] a, logic [5:0] b,
                                        logic [2:0] op, int w);
    logic [5:0] m;
    logic [5:0] r;
    m = 6'((1 << w) - 1);
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a & b);
      3'd4: r = ~(a | b);
      3'd5: r = ~(a ^ b);
      3'd6: r = ~a;
      default: r = ~b;
    endcase
    return r & m;
  endfunction

  function automatic logic [5:0] msk(logic [5:0] v, int w);
    return v & 6'((1 << w) - 1);
  endfunction

  task automatic sweep(int k, bit flt);
    int vecs, mexp, cyc, lim, dm_bad, dn_bad, mono_bad;
    int prev;
    vecs = 1 << (2 * wof(k));
    mexp = flt ? ((vecs > 255) ? 255 : vecs) : 0;
    lim  = vecs * sdof(k) + 10;
    fault_inj = flt;
    mode[k]   = 1'b1;
    start[k]  = 1'b1;
    tick();
    start[k]  = 1'b0;
    chk($sformatf("sw%0d_busy_on", k), 32'(bz_v[k]), 1);
    chk($sformatf("sw%0d_vc_clr", k), 32'(vc_v[k]), 0);
    chk($sformatf("sw%0d_mc_clr", k), 32'(mc_v[k]), 0);
    chk($sformatf("sw%0d_ab_clr", k), 32'({ac_v[k], bc_v[k]}), 0);
    cyc = 0; dm_bad = 0; dn_bad = 0; mono_bad = 0; prev = 0;
    while (bz_v[k] && cyc < lim) begin
      if (dm_v[k] !== !flt) dm_bad++;
      if (dn_v[k] !== 1'b0) dn_bad++;
      if (int'(vc_v[k]) < prev) mono_bad++;
      prev = int'(vc_v[k]);
      start[k] = (cyc == 5);
      tick();
      cyc++;
    end
    start[k] = 1'b0;
    chk($sformatf("sw%0d_run_cycles", k), 32'(cyc), 32'(vecs * sdof(k)));
    chk($sformatf("sw%0d_dm_run", k), 32'(dm_bad), 0);
    chk($sformatf("sw%0d_done_early", k), 32'(dn_bad), 0);
    chk($sformatf("sw%0d_vc_mono", k), 32'(mono_bad), 0);
    chk($sformatf("sw%0d_done", k), 32'(dn_v[k]), 1);
    chk($sformatf("sw%0d_vc", k), 32'(vc_v[k]), 32'(vecs));
    chk($sformatf("sw%0d_mc", k), 32'(mc_v[k]), 32'(mexp));
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
    chk($sformatf("sw%0d_done_1cyc", k), 32'(dn_v[k]), 0);
    chk($sformatf("sw%0d_no_restart", k), 32'(bz_v[k]), 0);
    mode[k]   = 1'b0;
    fault_inj = 1'b0;
    a_in = 6'($urandom);
    b_in = 6'($urandom);
    tick();
    chk($sformatf("sw%0d_track_a", k), 32'(ac_v[k]), 32'(msk(a_in, wof(k))));
    chk($sformatf("sw%0d_track_b", k), 32'(bc_v[k]), 32'(msk(b_in, wof(k))));
    chk($sformatf("sw%0d_vc_hold", k), 32'(vc_v[k]), 32'(vecs));
    chk($sformatf("sw%0d_mc_hold", k), 32'(mc_v[k]), 32'(mexp));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ra, rb;
    logic [2:0] rop;
    bit         rf;

    reset = 1'b1;
    tick();
    tick();
    chk("rst_a_cur", 32'(ac_v[0]), 0);
    chk("rst_b_cur", 32'(bc_v[0]), 0);
    chk("rst_result", 32'(res_v[0]), 0);
    chk("rst_dm", 32'(dm_v[0]), 0);
    chk("rst_busy", 32'(bz_v[0]), 0);
    chk("rst_done", 32'(dn_v[0]), 0);
    chk("rst_vc", 32'(vc_v[0]), 0);
    chk("rst_mc", 32'(mc_v[0]), 0);

    a_in = 6'h0C;
    b_in = 6'h0A;
    op_sel = 3'd0;
    reset = 1'b0;
    tick();
    chk("man_a_cur", 32'(ac_v[0]), 32'h0C);
    chk("man_b_cur", 32'(bc_v[0]), 32'h0A);
    tick();
    chk("man_and", 32'(res_v[0]), 32'h8);
    chk("man_dm", 32'(dm_v[0]), 1);
    op_sel = 3'd2;
    tick();
    chk("man_xor", 32'(res_v[0]), 32'h6);

    for (int i = 0; i < 24; i++) begin
      ra  = 6'($urandom);
      rb  = 6'($urandom);
      rop = 3'($urandom);
      rf  = 1'($urandom);
      a_in = ra;
      b_in = rb;
      op_sel = rop;
      fault_inj = rf;
      tick();
      tick();
      chk($sformatf("rnd%0d_res_w4", i), 32'(res_v[0]),
          32'(ref_op(msk(ra, 4), msk(rb, 4), rop, 4)));
      chk($sformatf("rnd%0d_res_w5", i), 32'(res_v[4]),
          32'(ref_op(msk(ra, 5), msk(rb, 5), rop, 5)));
      chk($sformatf("rnd%0d_dm", i), 32'(dm_v[0]), 32'(!rf));
    end
    fault_inj = 1'b0;

    a_in = 6'h03;
    b_in = 6'h02;
    mode[1]  = 1'b0;
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    chk("nostart_busy", 32'(bz_v[1]), 0);
    chk("nostart_track", 32'(ac_v[1]), 32'h3);

    sweep(1, 1'b0);
    sweep(2, 1'b1);
    sweep(4, 1'b1);
    sweep(0, 1'b0);

    mode[3]  = 1'b1;
    start[3] = 1'b1;
    tick();
    start[3] = 1'b0;
    chk("abort_busy_on", 32'(bz_v[3]), 1);
    repeat (10) tick();
    chk("abort_still_run", 32'(bz_v[3]), 1);
    mode[3] = 1'b0;
    tick();
    chk("abort_idle", 32'(bz_v[3]), 0);
    chk("abort_no_done", 32'(dn_v[3]), 0);
    chk("abort_vc", 32'(vc_v[3]), 32'(10 / sdof(3)));
    chk("abort_mc", 32'(mc_v[3]), 0);
    tick();
    chk("abort_vc_hold", 32'(vc_v[3]), 32'(10 / sdof(3)));
    chk("abort_done_hold", 32'(dn_v[3]), 0);

    op_sel   = 3'd3;
    mode[0]  = 1'b1;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      start[0] = (i == 20);
      tick();
    end
    start[0] = 1'b0;
    chk("mid_vc", 32'(vc_v[0]), 32'(40 / sdof(0)));
    chk("mid_busy", 32'(bz_v[0]), 1);
    a_in  = 6'h05;
    b_in  = 6'h09;
    reset = 1'b1;
    tick();
    chk("mrst_a_cur", 32'(ac_v[0]), 0);
    chk("mrst_b_cur", 32'(bc_v[0]), 0);
    chk("mrst_result", 32'(res_v[0]), 0);
    chk("mrst_dm", 32'(dm_v[0]), 0);
    chk("mrst_busy", 32'(bz_v[0]), 0);
    chk("mrst_done", 32'(dn_v[0]), 0);
    chk("mrst_vc", 32'(vc_v[0]), 0);
    chk("mrst_mc", 32'(mc_v[0]), 0);
    reset   = 1'b0;
    mode[0] = 1'b0;
    tick();
    chk("post_rst_a", 32'(ac_v[0]), 32'h5);
    chk("post_rst_b", 32'(bc_v[0]), 32'h9);
    chk("post_rst_busy", 32'(bz_v[0]), 0);
    tick();
    chk("post_rst_nand", 32'(res_v[0]), 32'(ref_op(6'h5, 6'h9, 3'd3, 4)));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
